muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the 54-instruction CPU. It executes MULT, MULTU, DIV and DIVU over a fixed 33-cycle sequence and produces the 64-bit {hi, lo} result pair. It sits directly upstream of the HI and LO special registers: `hi` and `lo` drive their data inputs, and `done` drives their write enables. The pipeline control stalls on `busy`.

---
 rtl/muldiv_unit.sv | 127 ++++++++++++
 tb/tb_muldiv_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: one radix-2 step per cycle,
// 32 steps plus one sign-fix cycle, feeding the HI/LO special registers.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_n;

    logic [CW-1:0]    cnt;
    logic             is_div, neg_res, neg_a, div_zero;
    logic [WIDTH-1:0] opnd_b, acc_hi, acc_lo;

    logic             signed_op;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_sum, sub_diff;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign signed_op = ~op[0];
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
    assign busy      = (state != IDLE);

    // acc_lo holds multiplier bits (multiply) or dividend bits (divide);
    // acc_hi is the partial product high half or the running remainder.
    assign add_sum  = {1'b0, acc_hi} + {1'b0, opnd_b};
    assign sub_diff = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd_b};

    always_comb begin
        step_hi = acc_hi;
        step_lo = acc_lo;
        if (is_div) begin
            if (!sub_diff[WIDTH]) begin
                step_hi = sub_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else if (acc_lo[0]) begin
            step_hi = add_sum[WIDTH:1];
            step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            step_hi = {1'b0, acc_hi[WIDTH-1:1]};
            step_lo = {acc_hi[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Remainder follows the dividend sign, which also returns hi=a on divide by zero.
    assign prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo_fix  = div_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
    assign rem_fix  = neg_a ? -acc_hi : acc_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (cnt == CW'(WIDTH-1)) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_a    <= 1'b0;
            div_zero <= 1'b0;
            opnd_b   <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: if (start) begin
                    cnt      <= '0;
                    is_div   <= op[1];
                    neg_a    <= signed_op & a[WIDTH-1];
                    neg_res  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    div_zero <= op[1] & (b == '0);
                    opnd_b   <= b_mag;
                    acc_hi   <= '0;
                    acc_lo   <= a_mag;
                end
                RUN: begin
                    cnt    <= cnt + 1'b1;
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand-written
// sequences for ignored start, back-to-back ops and mid-op reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op and wait for done; returns edges from start edge to done
    // and the number of sampled cycles with busy=1.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    vec_t vecs[10];
    int lat, bcnt, ndone;

    initial begin
        vecs[0] = '{"mult_neg3x5",   MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1] = '{"multu_max",     MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{"mult_m1xm1",    MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[3] = '{"mult_minx2",    MULT,  32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000};
        vecs[4] = '{"div_m7d2",      DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5] = '{"div_7dm2",      DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[6] = '{"divu_100d7",    DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[7] = '{"div_overflow",  DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[8] = '{"divu_by_zero",  DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF};
        vecs[9] = '{"div_by_zero_n", DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};

        // reset state
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk); rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            check({vecs[i].name, "_lat"}, 64'(lat), 64'd33);
            check({vecs[i].name, "_busycyc"}, 64'(bcnt), 64'd33);
            check({vecs[i].name, "_busy_at_done"}, 64'(busy), 64'd0);
            check({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].hi));
            check({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].lo));
            @(posedge clk); #1;
            check({vecs[i].name, "_done_1cyc"}, 64'(done), 64'd0);
        end

        // start while busy is ignored; operand changes mid-run have no effect
        @(negedge clk);
        start = 1'b1; op = MULTU; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; ndone = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 10) begin start = 1'b1; op = DIVU; a = 32'd9; b = 32'd3; end
            if (lat == 11) start = 1'b0;
            if (lat == 20) a = 32'd77;
        end
        check("ign_lat", 64'(lat), 64'd33);
        check("ign_hi", 64'(hi), 64'd0);
        check("ign_lo", 64'(lo), 64'd12);

        // back-to-back: start in the done cycle is accepted
        start = 1'b1; op = DIVU; a = 32'd9; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 100) begin
            if (done && busy) ndone++;
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_hi", 64'(hi), 64'd0);
        check("b2b_lo", 64'(lo), 64'd3);
        // no stray second done from the ignored DIVU request
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("b2b_no_extra_done", 64'(ndone), 64'd0);

        // reset mid-operation clears outputs asynchronously, no done follows
        @(negedge clk);
        start = 1'b1; op = DIV; a = 32'd50; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("arst_no_done", 64'(ndone), 64'd0);
        do_op(DIV, 32'd50, 32'hFFFFFFFB, lat, bcnt);
        check("arst_next_lat", 64'(lat), 64'd33);
        check("arst_next_hi", 64'(hi), 64'd0);
        check("arst_next_lo", 64'(lo), 64'(32'hFFFFFFF6));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
